// File: rtl/cpu_pkg.sv
// Shared CPU data-path constants and the machine word type.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int RAM_DEPTH  = 256;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/data_ram.sv
// Single-port word-addressed data memory: synchronous write, registered read
// with write-first forwarding, and a synchronous clear of every word on reset.
module data_ram #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int DEPTH      = cpu_pkg::RAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Only the low address bits select a word; the rest wrap away.
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] storage [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]      idx;
    logic                  unused_addr_hi;

    assign idx            = address[IDX_W-1:0];
    assign unused_addr_hi = ^address[ADDR_WIDTH-1:IDX_W];
    assign data_out       = data_q;

    // Clear everything on reset (dropping any write), else write-first or read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
            data_q <= '0;
        end else if (write_enable) begin
            storage[idx] <= data_in;
            data_q       <= data_in;
        end else begin
            data_q <= storage[idx];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed and randomized checks of data_ram against an array-based model.
module tb_data_ram;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_out;
    bit            out_known = 0;

    data_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive between edges, confirm the output held, then apply the
    // model's rule for this edge and compare output and the addressed word.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
        int k;
        @(negedge clk);
        reset = r; write_enable = we; address = a; data_in = d;
        #1;
        if (out_known) check({tag, "/hold"}, data_out, exp_out);
        @(posedge clk);
        k = int'(a % DEPTH);
        if (r) begin
            foreach (model_mem[j]) model_mem[j] = '0;
            exp_out = '0;
        end else if (we) begin
            model_mem[k] = d;
            exp_out      = d;
        end else begin
            exp_out = model_mem[k];
        end
        out_known = 1;
        #1;
        check({tag, "/dout"}, data_out, exp_out);
        check({tag, "/mem"}, dut.storage[k], model_mem[k]);
    endtask

    initial begin
        logic          r, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        foreach (model_mem[j]) model_mem[j] = '0;
        exp_out = '0;

        // 1: reset clears memory and output
        step(1'b1, 1'b0, 32'd0, 32'd0, "reset");
        for (int i = 0; i < 10; i++) check($sformatf("reset_mem%0d", i), dut.storage[i], 32'h0);

        // 2: write-first
        step(1'b0, 1'b1, 32'd3, 32'd7, "wr3");
        check("wr3_mem", dut.storage[3], 32'h7);
        check("wr3_out", data_out, 32'h0000_0007);

        // 3: reads
        step(1'b0, 1'b0, 32'd3, 32'd0, "rd3");
        check("rd3_out", data_out, 32'd7);
        step(1'b0, 1'b0, 32'd1, 32'd0, "rd1");
        check("rd1_out", data_out, 32'd0);
        step(1'b0, 1'b0, 32'd3, 32'd0, "rd3b");
        check("rd3b_out", data_out, 32'd7);

        // 4: reset mid-operation
        step(1'b1, 1'b0, 32'd0, 32'd0, "rst2");
        check("rst2_out", data_out, 32'd0);
        check("rst2_mem3", dut.storage[3], 32'd0);
        step(1'b0, 1'b0, 32'd3, 32'd0, "rd3c");
        check("rd3c_out", data_out, 32'd0);

        // 5: address wrap
        step(1'b0, 1'b1, DEPTH + 5, 32'hDEAD_BEEF, "wrwrap");
        check("wrwrap_mem5", dut.storage[5], 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'd5, 32'd0, "rdwrap");
        check("rdwrap_out", data_out, 32'hDEAD_BEEF);

        // 6: reset beats a simultaneous write
        step(1'b0, 1'b1, 32'd2, 32'h55, "pre2");
        step(1'b1, 1'b1, 32'd2, 32'd9, "rstwr");
        check("rstwr_mem2", dut.storage[2], 32'd0);
        check("rstwr_out", data_out, 32'd0);

        // randomized traffic, addresses clustered to revisit words
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            we = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) a = $urandom();
            else a = AW'($urandom_range(0, 15)) + (AW'($urandom_range(0, 3)) << 8);
            d  = $urandom();
            step(r, we, a, d, $sformatf("rnd%0d", n));
        end

        // final sweep of whole memory against the model
        for (int i = 0; i < DEPTH; i++) check($sformatf("sweep%0d", i), dut.storage[i], model_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
